// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Trap sequencer driving the CSR write port for interrupt and
//               exception entry (mepc, mstatus, mcause, then redirect to
//               mtvec) and for mret exit (mstatus, then redirect to mepc).
//               Optional macro TRAP_VECTORED_EN enables vectored interrupt
//               targets when mtvec[1:0] == 2'b01.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
  parameter int TRAP_SEQ_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  // Five states need at least three bits regardless of the parameter value.
  localparam int SEQ_W = (TRAP_SEQ_W < 3) ? 3 : TRAP_SEQ_W;

  localparam logic [31:0] C_ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] C_ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] C_ADDR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] C_CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] C_CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] C_CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] C_CAUSE_TIMER  = 32'h8000_0007;

  typedef enum logic [SEQ_W-1:0] {
    S_IDLE      = SEQ_W'(0),
    S_W_MEPC    = SEQ_W'(1),
    S_W_MSTATUS = SEQ_W'(2),
    S_W_MCAUSE  = SEQ_W'(3),
    S_JUMP      = SEQ_W'(4)
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_is_mret;
  logic [31:0] w_cause;
  logic        w_take_ext;
  logic        w_take_timer;

  logic [31:0] r_pc;
  logic [31:0] r_mstatus;
  logic [31:0] r_cause;
  logic        r_mret;

  logic [31:0] w_ms_trap;
  logic [31:0] w_ms_ret;
  logic [31:0] w_base;
  logic [31:0] w_trap_target;
  logic        w_unused;

  // Interrupts need a live instruction to squash, global MIE and their enable.
  assign w_take_ext   = irq_ext_i   & inst_valid_i & mstatus_i[3] & mie_i[11];
  assign w_take_timer = irq_timer_i & inst_valid_i & mstatus_i[3] & mie_i[7];

  // Entry: MPIE <- MIE, MIE <- 0.  Exit: MIE <- MPIE, MPIE <- 1.
  // Both derive from the captured mstatus so the value we just wrote is not
  // re-read through the CSR file one cycle too early.
  assign w_ms_trap = {r_mstatus[31:8], r_mstatus[3], r_mstatus[6:4], 1'b0, r_mstatus[2:0]};
  assign w_ms_ret  = {r_mstatus[31:8], 1'b1, r_mstatus[6:4], r_mstatus[7], r_mstatus[2:0]};

  assign w_base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Interrupts (cause[31] set) jump to base + 4*code in vectored mode.
  assign w_trap_target = (r_cause[31] && (mtvec_i[1:0] == 2'b01))
                       ? (w_base + {r_cause[29:0], 2'b00}) : w_base;
`else
  assign w_trap_target = w_base;
`endif

  assign w_unused = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0], mtvec_i[1:0]};

  // State register; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the trapping context when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_mstatus <= '0;
      r_cause   <= '0;
      r_mret    <= 1'b0;
    end else if (w_accept) begin
      r_pc      <= inst_addr_i;
      r_mstatus <= mstatus_i;
      r_cause   <= w_cause;
      r_mret    <= w_is_mret;
    end
  end

  // Request arbitration, next state and CSR/redirect outputs.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_is_mret    = 1'b0;
    w_cause      = '0;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    hold_o       = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (ecall_i) begin
          w_accept = 1'b1;
          w_cause  = C_CAUSE_ECALL;
        end else if (ebreak_i) begin
          w_accept = 1'b1;
          w_cause  = C_CAUSE_EBREAK;
        end else if (mret_i) begin
          w_accept  = 1'b1;
          w_is_mret = 1'b1;
        end else if (w_take_ext) begin
          w_accept = 1'b1;
          w_cause  = C_CAUSE_EXT;
        end else if (w_take_timer) begin
          w_accept = 1'b1;
          w_cause  = C_CAUSE_TIMER;
        end
        hold_o = w_accept;
        if (w_accept) begin
          w_next = w_is_mret ? S_W_MSTATUS : S_W_MEPC;
        end
      end
      S_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = C_ADDR_MEPC;
        csr_wdata_o = r_pc;
        w_next      = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = C_ADDR_MSTATUS;
        csr_wdata_o = r_mret ? w_ms_ret : w_ms_trap;
        w_next      = r_mret ? S_JUMP : S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = C_ADDR_MCAUSE;
        csr_wdata_o = r_cause;
        w_next      = S_JUMP;
      end
      S_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = r_mret ? mepc_i : w_trap_target;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Self-checking bench for trap_ctrl. A transaction-level model
//               turns each request into the expected list of CSR writes and
//               the redirect target, then the bench compares cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        ecall_i, ebreak_i, mret_i, irq_timer_i, irq_ext_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i, mie_i;
  logic        csr_we_o, hold_o, int_assert_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, int_addr_o;

  int checks   = 0;
  int failures = 0;

  trap_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid_i (inst_valid_i),
    .inst_addr_i  (inst_addr_i),
    .ecall_i      (ecall_i),
    .ebreak_i     (ebreak_i),
    .mret_i       (mret_i),
    .irq_timer_i  (irq_timer_i),
    .irq_ext_i    (irq_ext_i),
    .mtvec_i      (mtvec_i),
    .mepc_i       (mepc_i),
    .mstatus_i    (mstatus_i),
    .mie_i        (mie_i),
    .csr_we_o     (csr_we_o),
    .csr_waddr_o  (csr_waddr_o),
    .csr_wdata_o  (csr_wdata_o),
    .hold_o       (hold_o),
    .int_assert_o (int_assert_o),
    .int_addr_o   (int_addr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    inst_valid_i = 1'b0; inst_addr_i = '0;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    mtvec_i = '0; mepc_i = '0; mstatus_i = '0; mie_i = '0;
  endtask

  // One request through the model and the DUT, checked every cycle.
  task automatic run_txn(input string name,
                         input logic t_ecall, input logic t_ebreak, input logic t_mret,
                         input logic t_ext, input logic t_tmr, input logic t_valid,
                         input logic [31:0] t_pc, input logic [31:0] t_mtvec,
                         input logic [31:0] t_mepc, input logic [31:0] t_ms,
                         input logic [31:0] t_mie);
    int          kind;
    logic [31:0] cause;
    logic [31:0] jaddr;
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    kind = 0; cause = 0; jaddr = 0;
    if (t_ecall)       begin kind = 1; cause = 11; end
    else if (t_ebreak) begin kind = 1; cause = 3;  end
    else if (t_mret)   begin kind = 2; end
    else if (t_ext && t_valid && t_ms[3] && t_mie[11]) begin kind = 1; cause = 32'h8000000B; end
    else if (t_tmr && t_valid && t_ms[3] && t_mie[7])  begin kind = 1; cause = 32'h80000007; end

    if (kind == 1) begin
      ea.push_back(32'h341); ed.push_back(t_pc);
      ea.push_back(32'h300); ed.push_back((t_ms & ~32'h88) | (t_ms[3] ? 32'h80 : 32'h0));
      ea.push_back(32'h342); ed.push_back(cause);
      jaddr = t_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
      if (cause[31] && ((t_mtvec & 32'h3) == 32'h1))
        jaddr = jaddr + 4 * (cause & 32'h7FFFFFFF);
`endif
    end else if (kind == 2) begin
      ea.push_back(32'h300); ed.push_back((t_ms & ~32'h88) | 32'h80 | (t_ms[7] ? 32'h8 : 32'h0));
      jaddr = t_mepc;
    end

    @(posedge clk); #1;
    ecall_i = t_ecall; ebreak_i = t_ebreak; mret_i = t_mret;
    irq_ext_i = t_ext; irq_timer_i = t_tmr; inst_valid_i = t_valid;
    inst_addr_i = t_pc; mtvec_i = t_mtvec; mepc_i = t_mepc; mstatus_i = t_ms; mie_i = t_mie;
    @(negedge clk);
    checks++;
    if (hold_o !== (kind != 0)) begin
      failures++;
      $display("FAIL %s hold_cyc0: got %0b expected %0b", name, hold_o, (kind != 0));
    end
    checks++;
    if ({csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL %s idle_out_cyc0: we=%0b addr=%h data=%h assert=%0b expected all zero",
               name, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o);
    end

    for (int c = 1; c <= ea.size() + 1 && kind != 0; c++) begin
      @(posedge clk); #1;
      ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
      irq_ext_i = 1'($urandom_range(0, 1)); irq_timer_i = 1'($urandom_range(0, 1));
      inst_valid_i = 1'($urandom_range(0, 1));
      mstatus_i = $urandom; inst_addr_i = $urandom;
      @(negedge clk);
      checks++;
      if (c <= ea.size()) begin
        if ({csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, hold_o} !==
            {1'b1, ea[c-1], ed[c-1], 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL %s write_cyc%0d: we=%0b addr=%h data=%h assert=%0b hold=%0b expected we=1 addr=%h data=%h assert=0 hold=1",
                   name, c, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, hold_o, ea[c-1], ed[c-1]);
        end
      end else begin
        if ({csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, hold_o} !==
            {1'b0, 32'h0, 32'h0, 1'b1, jaddr, 1'b1}) begin
          failures++;
          $display("FAIL %s jump_cyc%0d: we=%0b addr=%h data=%h assert=%0b target=%h hold=%0b expected assert=1 target=%h hold=1",
                   name, c, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, hold_o, jaddr);
        end
      end
    end

    @(posedge clk); #1;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; irq_ext_i = 1'b0; irq_timer_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({hold_o, csr_we_o, int_assert_o} !== 3'b000) begin
      failures++;
      $display("FAIL %s back_to_idle: hold=%0b we=%0b assert=%0b expected 000",
               name, hold_o, csr_we_o, int_assert_o);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o} !== 99'h0) begin
      failures++;
      $display("FAIL reset_outputs: we=%0b addr=%h data=%h hold=%0b assert=%0b target=%h expected all zero",
               csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o);
    end
  endtask

  task automatic test_ecall();
    run_txn("ecall", 1, 0, 0, 0, 0, 1, 32'h100, 32'h200, 32'h0, 32'h8, 32'h0);
    run_txn("ebreak", 0, 1, 0, 0, 0, 1, 32'h0000_1234, 32'h0000_0400, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_mret();
    run_txn("mret", 0, 0, 1, 0, 0, 1, 32'h0, 32'h200, 32'h104, 32'h80, 32'h0);
  endtask

  task automatic test_irq_timer();
    run_txn("irq_timer", 0, 0, 0, 0, 1, 1, 32'h300, 32'h200, 32'h0, 32'h8, 32'h80);
    run_txn("irq_timer_masked", 0, 0, 0, 0, 1, 1, 32'h300, 32'h200, 32'h0, 32'h0, 32'h80);
    run_txn("irq_ext_noinst", 0, 0, 0, 1, 0, 0, 32'h300, 32'h200, 32'h0, 32'h8, 32'h800);
  endtask

  task automatic test_exc_and_irq();
    run_txn("ecall_with_ext", 1, 0, 0, 1, 0, 1, 32'h500, 32'h200, 32'h0, 32'h8, 32'h800);
    // CSR file now holds MIE=0; the still-pending IRQ must not be taken.
    #1;
    irq_ext_i = 1'b1; inst_valid_i = 1'b1; mstatus_i = 32'h80; mie_i = 32'h800;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({hold_o, csr_we_o, int_assert_o} !== 3'b000) begin
        failures++;
        $display("FAIL irq_after_entry_cyc%0d: hold=%0b we=%0b assert=%0b expected 000",
                 c, hold_o, csr_we_o, int_assert_o);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(posedge clk); #1;
    ecall_i = 1'b1; inst_valid_i = 1'b1; inst_addr_i = 32'h700; mtvec_i = 32'h200; mstatus_i = 32'h8;
    @(posedge clk); #1;
    ecall_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({csr_we_o, csr_waddr_o} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL reset_mid_pre: we=%0b addr=%h expected we=1 addr=00000300", csr_we_o, csr_waddr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({csr_we_o, hold_o, int_assert_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_abort: we=%0b hold=%0b assert=%0b expected 000", csr_we_o, hold_o, int_assert_o);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (int_assert_o || csr_we_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_pulse: got activity=%0b expected 0", seen);
    end
    clear_inputs();
  endtask

`ifdef TRAP_VECTORED_EN
  task automatic test_vectored();
    run_txn("vec_ext", 0, 0, 0, 1, 0, 1, 32'h600, 32'h201, 32'h0, 32'h8, 32'h800);
    run_txn("vec_ecall", 1, 0, 0, 0, 0, 1, 32'h600, 32'h201, 32'h0, 32'h8, 32'h800);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ms;
      ms = $urandom;
      run_txn("random",
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              $urandom, $urandom, $urandom, ms, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_irq_timer();
    test_exc_and_irq();
    test_reset_mid();
`ifdef TRAP_VECTORED_EN
    test_vectored();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
